// File: rtl/producer_arbiter.sv
// Purpose : round-robin merge of the fibonacci and timer producers into the single
//           write port of the GALS buffer, with a 1-deep holding slot per producer.
// Latency : valid captured at edge k, write strobe high after edge k+1 (2 cycles min).
// Backpressure: buffer_full stalls grants; slots hold data and the producer enables
//           fall as slots fill. A valid arriving into a full, ungranted slot is dropped
//           and counted in the saturating drop_cnt.
//
// Ports:
//   clock, reset           clock_1 domain clock, async active-high reset
//   start, stop            control pulses (rising-edge detected)
//   f_valid/f_data         fibonacci producer output
//   t_valid/t_data         timer producer output
//   buffer_full/empty      buffer status flags
//   data_2_valid           buffer read-side valid (drain must see it low)
//   f_en, t_en             producer enables
//   data_1_en/data_1/src   buffer write strobe, data and source (0 = fib, 1 = timer)
//   busy                   high in RUN or DRAIN
//   drop_cnt               saturating count of words lost to slot overflow
module producer_arbiter #(
    parameter int DATA_W = 16,
    parameter int DROP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              f_valid,
    input  logic [DATA_W-1:0] f_data,
    input  logic              t_valid,
    input  logic [DATA_W-1:0] t_data,
    input  logic              buffer_full,
    input  logic              buffer_empty,
    input  logic              data_2_valid,
    output logic              f_en,
    output logic              t_en,
    output logic              data_1_en,
    output logic [DATA_W-1:0] data_1,
    output logic              src,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t              state_q, state_d;
    logic                start_q, stop_q;
    logic                slot_f_full_q, slot_f_full_d;
    logic                slot_t_full_q, slot_t_full_d;
    logic [DATA_W-1:0]   slot_f_q, slot_f_d;
    logic [DATA_W-1:0]   slot_t_q, slot_t_d;
    logic                last_grant_q, last_grant_d;
    logic                data_1_en_q, data_1_en_d;
    logic [DATA_W-1:0]   data_1_q, data_1_d;
    logic                src_q, src_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic                start_evt, stop_evt;
    logic                run, active;
    logic                grant, grant_t, grant_f, grant_t_win;
    logic                f_drop, t_drop, f_load, t_load;
    logic [DROP_W:0]     drop_sum;

    assign start_evt = start && !start_q;
    assign stop_evt  = stop && !stop_q;
    assign run       = (state_q == RUN);
    assign active    = (state_q != IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_evt) state_d = RUN;
            RUN:     if (stop_evt)  state_d = DRAIN;
            DRAIN:   if (!slot_f_full_q && !slot_t_full_q && buffer_empty && !data_2_valid)
                         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        f_en = run && !slot_f_full_q;
        t_en = run && !slot_t_full_q;
        busy = active;
    end

    // ---------------- Arbitration and slot capture ----------------
    always_comb begin
        grant       = active && !buffer_full && (slot_f_full_q || slot_t_full_q);
        // On a tie the timer wins only if fibonacci was granted last.
        grant_t_win = slot_t_full_q && (!slot_f_full_q || !last_grant_q);
        grant_t     = grant && grant_t_win;
        grant_f     = grant && !grant_t_win;

        // A slot being emptied this edge can accept a new word without loss.
        f_drop = run && f_valid && slot_f_full_q && !grant_f;
        t_drop = run && t_valid && slot_t_full_q && !grant_t;
        f_load = run && f_valid && !f_drop;
        t_load = run && t_valid && !t_drop;

        slot_f_full_d = (slot_f_full_q && !grant_f) || f_load;
        slot_t_full_d = (slot_t_full_q && !grant_t) || t_load;
        slot_f_d      = f_load ? f_data : slot_f_q;
        slot_t_d      = t_load ? t_data : slot_t_q;

        data_1_en_d  = grant;
        data_1_d     = data_1_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            data_1_d     = grant_t ? slot_t_q : slot_f_q;
            src_d        = grant_t;
            last_grant_d = grant_t;
        end

        // One extra bit catches the overflow of adding up to two drops.
        drop_sum = {1'b0, drop_cnt_q} + (DROP_W+1)'(f_drop) + (DROP_W+1)'(t_drop);
        if (state_q == IDLE && start_evt) begin
            drop_cnt_d = '0;
        end else if (drop_sum[DROP_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[DROP_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            slot_f_full_q <= 1'b0;
            slot_t_full_q <= 1'b0;
            slot_f_q      <= '0;
            slot_t_q      <= '0;
            last_grant_q  <= 1'b1;
            data_1_en_q   <= 1'b0;
            data_1_q      <= '0;
            src_q         <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            start_q       <= start;
            stop_q        <= stop;
            slot_f_full_q <= slot_f_full_d;
            slot_t_full_q <= slot_t_full_d;
            slot_f_q      <= slot_f_d;
            slot_t_q      <= slot_t_d;
            last_grant_q  <= last_grant_d;
            data_1_en_q   <= data_1_en_d;
            data_1_q      <= data_1_d;
            src_q         <= src_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign data_1_en = data_1_en_q;
    assign data_1    = data_1_q;
    assign src       = src_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_producer_arbiter.sv
module tb_producer_arbiter;

    logic        clock;
    logic        reset;
    logic        start, stop;
    logic        f_valid, t_valid;
    logic [15:0] f_data, t_data;
    logic        buffer_full, buffer_empty, data_2_valid;
    logic        f_en, t_en, data_1_en, src, busy;
    logic [15:0] data_1;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fq[$];
    logic [15:0] tq[$];
    logic        srcq[$];

    producer_arbiter #(.DATA_W(16), .DROP_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .f_valid(f_valid), .f_data(f_data), .t_valid(t_valid), .t_data(t_data),
        .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
        .f_en(f_en), .t_en(t_en), .data_1_en(data_1_en), .data_1(data_1),
        .src(src), .busy(busy), .drop_cnt(drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected word of its source.
    task automatic mon();
        logic [15:0] e;
        if (data_1_en === 1'b1) begin
            if (srcq.size() > 0) chk("src_order", {31'd0, src}, {31'd0, srcq.pop_front()});
            if (src === 1'b0) begin
                chk("f_write_expected", fq.size(), (fq.size() > 0) ? fq.size() : 1);
                if (fq.size() > 0) begin
                    e = fq.pop_front();
                    chk("f_write_data", {16'd0, data_1}, {16'd0, e});
                end
            end else begin
                chk("t_write_expected", tq.size(), (tq.size() > 0) ? tq.size() : 1);
                if (tq.size() > 0) begin
                    e = tq.pop_front();
                    chk("t_write_data", {16'd0, data_1}, {16'd0, e});
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        mon();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_1_en"}, {31'd0, data_1_en}, 0);
        chk({tag, "_data_1"},    {16'd0, data_1},    0);
        chk({tag, "_src"},       {31'd0, src},       0);
        chk({tag, "_f_en"},      {31'd0, f_en},      0);
        chk({tag, "_t_en"},      {31'd0, t_en},      0);
        chk({tag, "_busy"},      {31'd0, busy},      0);
        chk({tag, "_drop_cnt"},  {24'd0, drop_cnt},  0);
    endtask

    task automatic chk_queues_empty(input string tag);
        chk({tag, "_fq_left"}, fq.size(), 0);
        chk({tag, "_tq_left"}, tq.size(), 0);
    endtask

    initial begin
        int fi, ti;
        reset = 1'b1; start = 0; stop = 0; f_valid = 0; t_valid = 0;
        f_data = '0; t_data = '0; buffer_full = 0; buffer_empty = 1; data_2_valid = 0;

        // ---- reset state ----
        tick(); tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 0);

        // ---- single fibonacci word, latency ----
        start = 1; tick(); start = 0;
        chk("run_busy", {31'd0, busy}, 1);
        chk("run_f_en", {31'd0, f_en}, 1);
        chk("run_t_en", {31'd0, t_en}, 1);
        f_valid = 1; f_data = 16'h0005; fq.push_back(16'h0005);
        tick();                               // capture edge
        f_valid = 0;
        chk("lat_no_early_write", {31'd0, data_1_en}, 0);
        chk("lat_f_en_slot_full", {31'd0, f_en}, 0);
        tick();                               // grant edge
        chk("lat_write", {31'd0, data_1_en}, 1);
        chk("lat_src", {31'd0, src}, 0);
        chk("lat_f_en_back", {31'd0, f_en}, 1);
        tick();
        chk("lat_single_strobe", {31'd0, data_1_en}, 0);
        chk_queues_empty("single");

        // ---- alternation from reset: fibonacci first ----
        reset = 1; tick(); reset = 0; tick();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            srcq.push_back(1'b0);
            srcq.push_back(1'b1);
        end
        fi = 0; ti = 0;
        for (int c = 0; c < 16; c++) begin
            f_valid = (fi < 4) && f_en;
            t_valid = (ti < 4) && t_en;
            if (f_valid) begin f_data = 16'h0008 + 16'(fi); fq.push_back(f_data); fi++; end
            if (t_valid) begin t_data = 16'h0100 + 16'(ti); tq.push_back(t_data); ti++; end
            tick();
        end
        f_valid = 0; t_valid = 0;
        tick(); tick();
        chk("alt_all_sent", fi + ti, 8);
        chk("alt_src_seq_done", srcq.size(), 0);
        chk("alt_drop_cnt", {24'd0, drop_cnt}, 0);
        chk_queues_empty("alt");

        // ---- buffer_full stalls, no loss ----
        buffer_full = 1;
        f_valid = 1; f_data = 16'h0020; fq.push_back(16'h0020);
        t_valid = 1; t_data = 16'h0200; tq.push_back(16'h0200);
        tick();
        f_valid = 0; t_valid = 0;
        chk("full_f_en_low", {31'd0, f_en}, 0);
        chk("full_t_en_low", {31'd0, t_en}, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("full_no_write", {31'd0, data_1_en}, 0);
        end
        buffer_full = 0;
        repeat (4) tick();
        chk_queues_empty("full");
        chk("full_drop_cnt", {24'd0, drop_cnt}, 0);

        // ---- drops and saturation ----
        buffer_full = 1;
        f_valid = 1; f_data = 16'h0030; fq.push_back(16'h0030);
        t_valid = 1; t_data = 16'h0300; tq.push_back(16'h0300);
        tick();
        f_data = 16'hDEAD; t_data = 16'hBEEF;  // both dropped: slots blocked
        tick();
        chk("drop_dual", {24'd0, drop_cnt}, 2);
        f_valid = 0;
        repeat (3) tick();
        chk("drop_t_consecutive", {24'd0, drop_cnt}, 5);
        repeat (295) tick();
        chk("drop_saturate", {24'd0, drop_cnt}, 255);
        t_valid = 0;
        buffer_full = 0;
        repeat (4) tick();
        chk_queues_empty("drop");

        // ---- stop with both slots full, drain ----
        buffer_full = 1;
        f_valid = 1; f_data = 16'h0040; fq.push_back(16'h0040);
        t_valid = 1; t_data = 16'h0400; tq.push_back(16'h0400);
        tick();
        f_valid = 0; t_valid = 0;
        stop = 1; buffer_full = 0; buffer_empty = 0; data_2_valid = 1;
        tick();
        stop = 0;
        chk("drain_busy", {31'd0, busy}, 1);
        chk("drain_f_en", {31'd0, f_en}, 0);
        chk("drain_t_en", {31'd0, t_en}, 0);
        f_valid = 1; f_data = 16'h4444;        // ignored while draining
        start = 1;                              // ignored while draining
        for (int c = 0; c < 4; c++) begin
            tick();
            start = 0;
            chk("drain_hold_busy", {31'd0, busy}, 1);
        end
        f_valid = 0;
        buffer_empty = 1;
        tick();
        chk("drain_wait_d2v", {31'd0, busy}, 1);
        data_2_valid = 0;
        tick();
        chk("drain_to_idle", {31'd0, busy}, 0);
        chk_queues_empty("drain");

        // ---- drop_cnt clears on IDLE->RUN ----
        start = 1; tick(); start = 0;
        chk("restart_busy", {31'd0, busy}, 1);
        chk("restart_drop_clear", {24'd0, drop_cnt}, 0);

        // ---- reset during RUN with a pending word ----
        buffer_full = 1;
        f_valid = 1; f_data = 16'h0055;
        tick();
        f_valid = 0;
        chk("rst_pending_f_en", {31'd0, f_en}, 0);
        #2 reset = 1;
        #1;
        chk("rst_async_data_1", {16'd0, data_1}, 0);
        chk_reset_outputs("rst_async");
        buffer_full = 0;
        tick();
        reset = 0;
        repeat (4) tick();
        chk("rst_no_write_busy", {31'd0, busy}, 0);
        chk("rst_no_write_data", {16'd0, data_1}, 0);
        chk_queues_empty("rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
